// File: rtl/seq_pkg.sv
// Shared definitions for the "1001" sequence path, used by both the
// transmitter and the detector side so both agree on pattern and encoding.
package seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 3;

  localparam logic [3:0] PATTERN_1001 = 4'b1001;

  // Plain constants rather than an enum so legacy detector code can share them.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t SEND = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/seq_match_counter.sv
// Saturating counter of overlapping PATTERN occurrences in a serial bit stream.
// Shared by transmitter and receiver so both ends count identically.
module seq_match_counter
  import seq_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_1001,
  parameter int               CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             bit_en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  localparam int               SEEN_W    = $clog2(PAT_W + 1);
  localparam logic [SEEN_W-1:0] SEEN_FULL = SEEN_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-1:0]  history_q, history_d;
  logic [SEEN_W-1:0] seen_q, seen_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // seen_q saturates at PAT_W-1: once PAT_W-1 bits precede the incoming one,
  // the history is fully populated and a match cannot come from cleared bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    history_d = history_q;
    seen_d    = seen_q;
    count_d   = count_q;
    if (clear) begin
      history_d = '0;
      seen_d    = '0;
      count_d   = '0;
    end else if (bit_en) begin
      history_d = {history_q[PAT_W-2:0], bit_in};
      if (seen_q != SEEN_FULL) begin
        seen_d = seen_q + SEEN_W'(1);
      end
      if (history_d == PATTERN && seen_q == SEEN_FULL && count_q != CNT_MAX) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history_q <= '0;
      seen_q    <= '0;
      count_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      history_q <= history_d;
      seen_q    <= seen_d;
      count_q   <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial MSB-first frame transmitter with valid/ready handshake that also
// counts PATTERN occurrences in the bits actually accepted by the sink.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               WIDTH   = WIDTH_DEF,
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_1001,
  parameter int               CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  localparam int            SENT_W    = $clog2(WIDTH + 1);
  localparam logic [SENT_W-1:0] SENT_LAST = SENT_W'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [SENT_W-1:0] sent_q, sent_d;
  logic              bit_valid_q, bit_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clear;
  logic              transfer;

  assign transfer = (state_q == SEND) && bit_valid_q && bit_ready;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    sent_d      = sent_q;
    bit_valid_d = bit_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    clear       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d     = data_in;
          sent_d      = '0;
          bit_valid_d = 1'b1;
          busy_d      = 1'b1;
          clear       = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        // Without a transfer everything holds, so bit_out/bit_valid stay stable under backpressure.
        if (transfer) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          sent_d  = sent_q + SENT_W'(1);
          if (sent_q == SENT_LAST) begin
            bit_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        bit_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      sent_q      <= '0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      sent_q      <= sent_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  seq_match_counter #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) u_match_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .bit_en (transfer),
    .bit_in (shift_q[WIDTH-1]),
    .count  (match_count)
  );

  assign bit_out   = shift_q[WIDTH-1];
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: default instance plus a CNT_W=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_seq_pattern_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] data_in;
  logic        bit_ready;

  logic        bit_out, bit_valid, busy, done;
  logic [2:0]  match_count;
  logic        bit_out_s, bit_valid_s, busy_s, done_s;
  logic [1:0]  match_count_s;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          first_cyc;
    int          done_cyc;
    int          last_xfer;
    int          stall_err;
    logic [2:0]  count_c1;
    logic        busy_at_done;
    logic        post_busy;
    logic        post_done;
    logic        post_valid;
  } frame_t;

  always #5 clk = ~clk;

  seq_pattern_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data_in     (data_in),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .busy        (busy),
    .done        (done),
    .match_count (match_count)
  );

  seq_pattern_tx #(.CNT_W(2)) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data_in     (data_in),
    .bit_out     (bit_out_s),
    .bit_valid   (bit_valid_s),
    .bit_ready   (bit_ready),
    .busy        (busy_s),
    .done        (done_s),
    .match_count (match_count_s)
  );

  // Runs one frame from the current (IDLE) cycle; cycle 1 is the cycle after the start edge.
  // toggle selects ready pattern 1,0,0 repeating; glitch_cyc pulses start with other data mid-frame.
  task automatic run_frame(input logic [15:0] data, input bit toggle, input int glitch_cyc,
                           output frame_t r);
    logic held_bit;
    bit   stalled;
    int   cyc;
    r.bits = '0; r.nbits = 0; r.first_cyc = -1; r.done_cyc = -1; r.last_xfer = -1;
    r.stall_err = 0; r.busy_at_done = 1'b0;
    held_bit = 1'b0;
    start = 1'b1; data_in = data; bit_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; data_in = 16'h0000;
    r.count_c1 = match_count;
    stalled = 1'b0;
    cyc = 1;
    while (cyc < 200 && r.done_cyc < 0) begin
      start   = (cyc == glitch_cyc);
      data_in = (cyc == glitch_cyc) ? 16'hFFFF : 16'h0000;
      if (stalled && (bit_valid !== 1'b1 || bit_out !== held_bit)) r.stall_err++;
      stalled = 1'b0;
      if (done === 1'b1) begin
        r.done_cyc     = cyc;
        r.busy_at_done = busy;
      end else if (bit_valid === 1'b1) begin
        bit_ready = toggle ? ((cyc - 1) % 3 == 0) : 1'b1;
        if (bit_ready) begin
          if (r.nbits < 16) r.bits[15 - r.nbits] = bit_out;
          r.nbits++;
          if (r.first_cyc < 0) r.first_cyc = cyc;
          r.last_xfer = cyc;
        end else begin
          stalled  = 1'b1;
          held_bit = bit_out;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; data_in = 16'h0000; bit_ready = 1'b1;
    r.post_busy  = busy;
    r.post_done  = done;
    r.post_valid = bit_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; data_in = 16'h0000; bit_ready = 1'b0;
    #12;
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out: got %b expected 0", bit_out); end
    checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid: got %b expected 0", bit_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (match_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", match_count); end
    @(negedge clk); rst_n = 1'b1;
    bit_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bit_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_ready_no_effect: got valid=%b busy=%b expected 0 0", bit_valid, busy);
    end
  endtask

  task automatic test_basic();
    frame_t r;
    run_frame(16'b1001100110010010, 1'b0, -1, r);
    checks++; if (r.bits !== 16'b1001100110010010) begin errors++; $display("FAIL basic_bits: got %b expected 1001100110010010", r.bits); end
    checks++; if (r.nbits !== 16) begin errors++; $display("FAIL basic_nbits: got %0d expected 16", r.nbits); end
    checks++; if (r.first_cyc !== 1) begin errors++; $display("FAIL basic_first_bit_cycle: got %0d expected 1", r.first_cyc); end
    checks++; if (r.done_cyc !== 17) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 17", r.done_cyc); end
    checks++; if (r.busy_at_done !== 1'b1) begin errors++; $display("FAIL basic_busy_in_done: got %b expected 1", r.busy_at_done); end
    checks++; if (r.post_busy !== 1'b0 || r.post_done !== 1'b0 || r.post_valid !== 1'b0) begin
      errors++; $display("FAIL basic_after_done: got busy=%b done=%b valid=%b expected 0 0 0", r.post_busy, r.post_done, r.post_valid);
    end
    checks++; if (match_count !== 3'd4) begin errors++; $display("FAIL basic_count: got %0d expected 4", match_count); end
  endtask

  task automatic test_saturation();
    frame_t r;
    run_frame(16'b1001001001001001, 1'b0, -1, r);
    checks++; if (match_count !== 3'd5) begin errors++; $display("FAIL sat_raw_count: got %0d expected 5", match_count); end
    checks++; if (match_count_s !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d expected 3", match_count_s); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (match_count_s !== 2'd3 || match_count !== 3'd5) begin
      errors++; $display("FAIL sat_count_holds: got sat=%0d raw=%0d expected 3 5", match_count_s, match_count);
    end
  endtask

  task automatic test_back_to_back();
    frame_t r;
    run_frame(16'h9999, 1'b0, -1, r);
    checks++; if (match_count !== 3'd4) begin errors++; $display("FAIL b2b_first_count: got %0d expected 4", match_count); end
    run_frame(16'hFFFF, 1'b0, -1, r);
    checks++; if (r.count_c1 !== 3'd0) begin errors++; $display("FAIL b2b_count_cleared: got %0d expected 0", r.count_c1); end
    checks++; if (r.bits !== 16'hFFFF || r.done_cyc !== 17) begin
      errors++; $display("FAIL b2b_ffff_frame: got bits=%h done_cyc=%0d expected ffff 17", r.bits, r.done_cyc);
    end
    checks++; if (match_count !== 3'd0) begin errors++; $display("FAIL b2b_ffff_count: got %0d expected 0", match_count); end
    run_frame(16'h0000, 1'b0, -1, r);
    checks++; if (r.bits !== 16'h0000 || r.done_cyc !== 17) begin
      errors++; $display("FAIL b2b_zero_frame: got bits=%h done_cyc=%0d expected 0000 17", r.bits, r.done_cyc);
    end
    checks++; if (match_count !== 3'd0) begin errors++; $display("FAIL b2b_zero_count: got %0d expected 0", match_count); end
  endtask

  task automatic test_backpressure();
    frame_t r;
    run_frame(16'h9999, 1'b1, -1, r);
    checks++; if (r.stall_err !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes expected 0", r.stall_err); end
    checks++; if (r.nbits !== 16 || r.bits !== 16'h9999) begin
      errors++; $display("FAIL bp_transfers: got n=%0d bits=%h expected 16 9999", r.nbits, r.bits);
    end
    checks++; if (r.last_xfer !== 46 || r.done_cyc !== 47) begin
      errors++; $display("FAIL bp_done_timing: got last=%0d done=%0d expected 46 47", r.last_xfer, r.done_cyc);
    end
    checks++; if (match_count !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d expected 4", match_count); end
  endtask

  task automatic test_mid_start();
    frame_t r;
    run_frame(16'hA5C3, 1'b0, 5, r);
    checks++; if (r.bits !== 16'hA5C3 || r.done_cyc !== 17) begin
      errors++; $display("FAIL mid_start_frame: got bits=%h done_cyc=%0d expected a5c3 17", r.bits, r.done_cyc);
    end
    checks++; if (match_count !== 3'd1) begin errors++; $display("FAIL mid_start_count: got %0d expected 1", match_count); end
  endtask

  task automatic test_abort();
    frame_t r;
    bit     bad;
    start = 1'b1; data_in = 16'h9999; bit_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; data_in = 16'h0000;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (bit_valid !== 1'b1 || bit_out !== 1'b1 || match_count !== 3'd1) begin
      errors++; $display("FAIL abort_precondition: got valid=%b bit=%b count=%0d expected 1 1 1", bit_valid, bit_out, match_count);
    end
    rst_n = 1'b0;
    #1;
    checks++; if ({bit_out, bit_valid, busy, done} !== 4'b0000 || match_count !== 3'd0) begin
      errors++; $display("FAIL abort_async_clear: got out/valid/busy/done=%b count=%0d expected 0000 0",
                         {bit_out, bit_valid, busy, done}, match_count);
    end
    bad = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done !== 1'b0) bad = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || bit_valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL abort_no_done_no_restart: got activity expected idle"); end
    run_frame(16'h9999, 1'b0, -1, r);
    checks++; if (r.bits !== 16'h9999 || r.done_cyc !== 17 || match_count !== 3'd4) begin
      errors++; $display("FAIL abort_clean_frame: got bits=%h done_cyc=%0d count=%0d expected 9999 17 4",
                         r.bits, r.done_cyc, match_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_mid_start();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
